// File: rtl/accum_sched_if.sv
// accum_sched_if: command, psum, accumulator and output-buffer signals of accum_sched.
// slave = the sequencer side, master = the surrounding datapath/controller side.
interface accum_sched_if #(
   parameter int BIAS_WIDTH    = 32,
   parameter int FC_WCOL_WIDTH = 5,
   parameter int OUT_CNT_WIDTH = 10,
   parameter int BEAT_WIDTH    = 8
);
   logic                     cmd_valid;
   logic                     cmd_ready;
   logic                     cmd_layer;
   logic [OUT_CNT_WIDTH-1:0] cmd_num_out;
   logic [FC_WCOL_WIDTH-1:0] cmd_fc_wcol;
   logic [BEAT_WIDTH-1:0]    cmd_beat_len;
   logic                     psum_valid;
   logic [BIAS_WIDTH-1:0]    bias_in;
   logic [BIAS_WIDTH-1:0]    acc_sum;
   logic                     acc_conv_comp;
   logic                     acc_fc_done;
   logic                     acc_enable;
   logic                     acc_layer;
   logic [FC_WCOL_WIDTH-1:0] acc_fc_wcol;
   logic [BIAS_WIDTH-1:0]    acc_bias;
   logic                     acc_clr;
   logic [OUT_CNT_WIDTH-1:0] bias_addr;
   logic                     out_valid;
   logic [BIAS_WIDTH-1:0]    out_data;
   logic [OUT_CNT_WIDTH-1:0] out_idx;
   logic                     busy;
   logic                     done;
   logic                     err;

   modport slave (
      input  cmd_valid, cmd_layer, cmd_num_out, cmd_fc_wcol, cmd_beat_len,
             psum_valid, bias_in, acc_sum, acc_conv_comp, acc_fc_done,
      output cmd_ready, acc_enable, acc_layer, acc_fc_wcol, acc_bias, acc_clr,
             bias_addr, out_valid, out_data, out_idx, busy, done, err
   );

   modport master (
      output cmd_valid, cmd_layer, cmd_num_out, cmd_fc_wcol, cmd_beat_len,
             psum_valid, bias_in, acc_sum, acc_conv_comp, acc_fc_done,
      input  cmd_ready, acc_enable, acc_layer, acc_fc_wcol, acc_bias, acc_clr,
             bias_addr, out_valid, out_data, out_idx, busy, done, err
   );
endinterface

// File: rtl/accum_sched.sv
// accum_sched: runs one CONV or FC command over the accumulator and streams finished sums out.
// Optional watchdog on F_WAIT / C_DRAIN: define ACCUM_SCHED_TIMEOUT_EN.
module accum_sched #(
   parameter int BIAS_WIDTH    = 32,
   parameter int FC_WCOL_WIDTH = 5,
   parameter int OUT_CNT_WIDTH = 10,
   parameter int BEAT_WIDTH    = 8,
   parameter int TIMEOUT_CYC   = 255
) (
   input  logic         i_clk,
   input  logic         i_rst,
   accum_sched_if.slave io_bus
);
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_C_RUN   = 3'd1,
      S_C_DRAIN = 3'd2,
      S_F_BURST = 3'd3,
      S_F_GAP   = 3'd4,
      S_F_WAIT  = 3'd5,
      S_F_CLR   = 3'd6,
      S_FIN     = 3'd7
   } state_t;

   state_t                   r_state;
   logic                     r_layer;
   logic [OUT_CNT_WIDTH-1:0] r_last_idx;
   logic [FC_WCOL_WIDTH-1:0] r_fc_wcol;
   logic [BEAT_WIDTH-1:0]    r_last_beat;
   logic [OUT_CNT_WIDTH-1:0] r_idx;
   logic [FC_WCOL_WIDTH-1:0] r_burst;
   logic [BEAT_WIDTH-1:0]    r_beat;
   logic                     r_gap;
   logic                     r_abort;
   logic [1:0]               r_vpipe;
   logic                     r_cmd_ready;
   logic                     r_busy;
   logic                     r_acc_enable;
   logic                     r_acc_clr;
   logic [BIAS_WIDTH-1:0]    r_acc_bias;
   logic                     r_out_valid;
   logic [BIAS_WIDTH-1:0]    r_out_data;
   logic [OUT_CNT_WIDTH-1:0] r_out_idx;
   logic                     r_done;
   logic                     w_conv_hit;

   // A CONV result is only real when its psum vector entered the accumulator two cycles ago.
   assign w_conv_hit = io_bus.acc_conv_comp & r_vpipe[1];

`ifdef ACCUM_SCHED_TIMEOUT_EN
   localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
   logic [WD_W-1:0] r_wdog;
   logic            r_err;
   logic            w_wd_expire;
   assign w_wd_expire = ((r_state == S_F_WAIT) || (r_state == S_C_DRAIN)) &&
                        (r_wdog == WD_W'(TIMEOUT_CYC - 1));
   assign io_bus.err  = r_err;
`else
   assign io_bus.err  = 1'b0;
`endif

   // Sequencer state, counters and every registered output.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_layer      <= 1'b0;
         r_last_idx   <= OUT_CNT_WIDTH'(0);
         r_fc_wcol    <= FC_WCOL_WIDTH'(0);
         r_last_beat  <= BEAT_WIDTH'(0);
         r_idx        <= OUT_CNT_WIDTH'(0);
         r_burst      <= FC_WCOL_WIDTH'(0);
         r_beat       <= BEAT_WIDTH'(0);
         r_gap        <= 1'b0;
         r_abort      <= 1'b0;
         r_vpipe      <= 2'b00;
         r_cmd_ready  <= 1'b1;
         r_busy       <= 1'b0;
         r_acc_enable <= 1'b0;
         r_acc_clr    <= 1'b0;
         r_acc_bias   <= BIAS_WIDTH'(0);
         r_out_valid  <= 1'b0;
         r_out_data   <= BIAS_WIDTH'(0);
         r_out_idx    <= OUT_CNT_WIDTH'(0);
         r_done       <= 1'b0;
`ifdef ACCUM_SCHED_TIMEOUT_EN
         r_wdog       <= WD_W'(0);
         r_err        <= 1'b0;
`endif
      end else begin
         r_vpipe     <= {r_vpipe[0], io_bus.psum_valid};
         r_acc_bias  <= io_bus.bias_in;
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
         r_acc_clr   <= 1'b0;
`ifdef ACCUM_SCHED_TIMEOUT_EN
         r_wdog <= ((r_state == S_F_WAIT) || (r_state == S_C_DRAIN)) ? r_wdog + WD_W'(1) : WD_W'(0);
         if (w_wd_expire) begin
            // Give up on the pending output: clear, then finish without emitting it.
            r_err        <= 1'b1;
            r_wdog       <= WD_W'(0);
            r_abort      <= 1'b1;
            r_gap        <= 1'b0;
            r_acc_enable <= 1'b0;
            r_acc_clr    <= 1'b1;
            r_state      <= S_F_CLR;
         end else
`endif
         case (r_state)
            S_IDLE: begin
               if (io_bus.cmd_valid && r_cmd_ready) begin
                  r_layer      <= io_bus.cmd_layer;
                  r_last_idx   <= (io_bus.cmd_num_out == OUT_CNT_WIDTH'(0)) ? OUT_CNT_WIDTH'(0)
                                  : io_bus.cmd_num_out - OUT_CNT_WIDTH'(1);
                  r_fc_wcol    <= io_bus.cmd_fc_wcol;
                  r_last_beat  <= (io_bus.cmd_beat_len == BEAT_WIDTH'(0)) ? BEAT_WIDTH'(0)
                                  : io_bus.cmd_beat_len - BEAT_WIDTH'(1);
                  r_idx        <= OUT_CNT_WIDTH'(0);
                  r_burst      <= FC_WCOL_WIDTH'(0);
                  r_beat       <= BEAT_WIDTH'(0);
                  r_gap        <= 1'b0;
                  r_abort      <= 1'b0;
                  r_cmd_ready  <= 1'b0;
                  r_busy       <= 1'b1;
                  r_acc_enable <= 1'b1;
                  r_state      <= io_bus.cmd_layer ? S_F_BURST : S_C_RUN;
               end else begin
                  r_cmd_ready  <= 1'b1;
               end
            end
            S_C_RUN: begin
               if (w_conv_hit) begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= io_bus.acc_sum;
                  r_out_idx   <= r_idx;
                  if (r_idx == r_last_idx) begin
                     r_acc_enable <= 1'b0;
                     r_gap        <= 1'b0;
                     r_state      <= S_C_DRAIN;
                  end else begin
                     r_idx <= r_idx + OUT_CNT_WIDTH'(1);
                  end
               end
            end
            S_C_DRAIN: begin
               if (r_gap) begin
                  r_done    <= 1'b1;
                  r_acc_clr <= 1'b1;
                  r_state   <= S_FIN;
               end else begin
                  r_gap <= 1'b1;
               end
            end
            S_F_BURST: begin
               if (io_bus.psum_valid) begin
                  if (r_beat == r_last_beat) begin
                     r_acc_enable <= 1'b0;
                     r_gap        <= 1'b0;
                     r_state      <= S_F_GAP;
                  end else begin
                     r_beat <= r_beat + BEAT_WIDTH'(1);
                  end
               end
            end
            S_F_GAP: begin
               if (r_gap) begin
                  r_gap <= 1'b0;
                  if (r_burst < r_fc_wcol) begin
                     r_burst      <= r_burst + FC_WCOL_WIDTH'(1);
                     r_beat       <= BEAT_WIDTH'(0);
                     r_acc_enable <= 1'b1;
                     r_state      <= S_F_BURST;
                  end else begin
                     r_state <= S_F_WAIT;
                  end
               end else begin
                  r_gap <= 1'b1;
               end
            end
            S_F_WAIT: begin
               if (io_bus.acc_fc_done) begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= io_bus.acc_sum;
                  r_out_idx   <= r_idx;
                  r_acc_clr   <= 1'b1;
                  r_gap       <= 1'b0;
                  r_state     <= S_F_CLR;
               end
            end
            S_F_CLR: begin
               // Second F_CLR cycle is idle so bias_addr/acc_bias settle before the next neuron.
               if (!r_gap) begin
                  if ((r_idx == r_last_idx) || r_abort) begin
                     r_done    <= 1'b1;
                     r_acc_clr <= 1'b1;
                     r_state   <= S_FIN;
                  end else begin
                     r_idx <= r_idx + OUT_CNT_WIDTH'(1);
                     r_gap <= 1'b1;
                  end
               end else begin
                  r_gap        <= 1'b0;
                  r_burst      <= FC_WCOL_WIDTH'(0);
                  r_beat       <= BEAT_WIDTH'(0);
                  r_acc_enable <= 1'b1;
                  r_state      <= S_F_BURST;
               end
            end
            S_FIN: begin
               r_cmd_ready <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: begin
               r_acc_enable <= 1'b0;
               r_cmd_ready  <= 1'b1;
               r_busy       <= 1'b0;
               r_state      <= S_IDLE;
            end
         endcase
      end
   end

   // Reset clears the accumulator in the same cycle, before the registers can react.
   assign io_bus.acc_clr     = r_acc_clr | i_rst;
   assign io_bus.cmd_ready   = r_cmd_ready;
   assign io_bus.busy        = r_busy;
   assign io_bus.acc_enable  = r_acc_enable;
   assign io_bus.acc_layer   = r_layer;
   assign io_bus.acc_fc_wcol = r_fc_wcol;
   assign io_bus.acc_bias    = r_acc_bias;
   assign io_bus.bias_addr   = r_idx;
   assign io_bus.out_valid   = r_out_valid;
   assign io_bus.out_data    = r_out_data;
   assign io_bus.out_idx     = r_out_idx;
   assign io_bus.done        = r_done;
endmodule

// File: tb/tb_accum_sched.sv
// tb_accum_sched: directed, self-checking bench for accum_sched (reset, CONV, FC, stall, edge inputs).
// With ACCUM_SCHED_TIMEOUT_EN defined it also exercises the watchdog with TIMEOUT_CYC = 16.
module tb_accum_sched;
`ifdef ACCUM_SCHED_TIMEOUT_EN
   localparam int TCYC = 16;
`else
   localparam int TCYC = 255;
`endif

   logic clk;
   logic rst;
   int   total;
   int   bad;

   accum_sched_if #(.BIAS_WIDTH(32), .FC_WCOL_WIDTH(5), .OUT_CNT_WIDTH(10), .BEAT_WIDTH(8)) bus ();

   accum_sched #(
      .BIAS_WIDTH(32), .FC_WCOL_WIDTH(5), .OUT_CNT_WIDTH(10), .BEAT_WIDTH(8), .TIMEOUT_CYC(TCYC)
   ) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic layer, input logic [9:0] num, input logic [4:0] wcol,
                        input logic [7:0] beat);
      bus.cmd_layer    = layer;
      bus.cmd_num_out  = num;
      bus.cmd_fc_wcol  = wcol;
      bus.cmd_beat_len = beat;
      bus.cmd_valid    = 1'b1;
      tick();
      bus.cmd_valid    = 1'b0;
   endtask

   logic [11:0] stall_pat;

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.cmd_valid = 1'b0;  bus.cmd_layer = 1'b0;  bus.cmd_num_out = 10'd0;
      bus.cmd_fc_wcol = 5'd0; bus.cmd_beat_len = 8'd0; bus.psum_valid = 1'b0;
      bus.bias_in = 32'd0;   bus.acc_sum = 32'd0;   bus.acc_conv_comp = 1'b0;
      bus.acc_fc_done = 1'b0;

      // ---------------- power-on reset ----------------
      tick();
      chk("por_clr", bus.acc_clr, 1'b1);
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("por_ready", bus.cmd_ready, 1'b1);
      chk("por_busy", bus.busy, 1'b0);
      chk("por_en", bus.acc_enable, 1'b0);
      chk("por_valid", bus.out_valid, 1'b0);
      chk("por_done", bus.done, 1'b0);
      chk("por_clr0", bus.acc_clr, 1'b0);
      chk("por_err", bus.err, 1'b0);

      // ---------------- reset mid-F_BURST ----------------
      bus.psum_valid = 1'b1;
      issue(1'b1, 10'd1, 5'd0, 8'd5);
      chk("rb_en", bus.acc_enable, 1'b1);
      chk("rb_busy", bus.busy, 1'b1);
      tick();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rb_clr_in_rst", bus.acc_clr, 1'b1);
      end
      rst = 1'b0;
      tick();
      chk("rb_ready", bus.cmd_ready, 1'b1);
      chk("rb_busy0", bus.busy, 1'b0);
      chk("rb_en0", bus.acc_enable, 1'b0);
      chk("rb_clr0", bus.acc_clr, 1'b0);
      chk("rb_done0", bus.done, 1'b0);

      // ---------------- CONV, num_out = 4 ----------------
      issue(1'b0, 10'd4, 5'd0, 8'd0);
      chk("cv_en", bus.acc_enable, 1'b1);
      chk("cv_layer", bus.acc_layer, 1'b0);
      chk("cv_ready", bus.cmd_ready, 1'b0);
      begin
         logic [9:0] exp_i;
         exp_i = 10'd0;
         for (int k = 1; k <= 5; k++) begin
            bus.acc_conv_comp = (k != 3);
            bus.acc_sum       = 32'h0000_1000 + 32'(k);
            tick();
            if (k != 3) begin
               chk("cv_valid", bus.out_valid, 1'b1);
               chk("cv_data", bus.out_data, 32'h0000_1000 + 32'(k));
               chk("cv_idx", bus.out_idx, exp_i);
               exp_i = exp_i + 10'd1;
            end else begin
               chk("cv_gap_valid", bus.out_valid, 1'b0);
            end
            chk("cv_en_k", bus.acc_enable, (k < 5) ? 1'b1 : 1'b0);
         end
      end
      bus.acc_conv_comp = 1'b0;
      tick();
      chk("cv_drain_valid", bus.out_valid, 1'b0);
      chk("cv_drain_done", bus.done, 1'b0);
      tick();
      chk("cv_done", bus.done, 1'b1);
      chk("cv_fin_clr", bus.acc_clr, 1'b1);
      tick();
      chk("cv_done_off", bus.done, 1'b0);
      chk("cv_idle_ready", bus.cmd_ready, 1'b1);
      chk("cv_idle_busy", bus.busy, 1'b0);

      // ---------------- FC, num_out = 2, fc_wcol = 2, beat_len = 3 ----------------
      bus.bias_in = 32'hCAFE_0001;
      issue(1'b1, 10'd2, 5'd2, 8'd3);
      chk("fc_layer", bus.acc_layer, 1'b1);
      chk("fc_wcol", bus.acc_fc_wcol, 5'd2);
      chk("fc_bias", bus.acc_bias, 32'hCAFE_0001);
      chk("fc_addr0", bus.bias_addr, 10'd0);
      for (int k = 0; k <= 15; k++) begin
         if (k > 0) tick();
         chk("fc_n0_en", bus.acc_enable, ((k < 15) && ((k % 5) < 3)) ? 1'b1 : 1'b0);
      end
      tick(); tick();
      chk("fc_wait_valid", bus.out_valid, 1'b0);
      chk("fc_wait_en", bus.acc_enable, 1'b0);
      bus.acc_fc_done = 1'b1;
      bus.acc_sum     = 32'h0000_00AA;
      tick();
      bus.acc_fc_done = 1'b0;
      chk("fc_n0_valid", bus.out_valid, 1'b1);
      chk("fc_n0_data", bus.out_data, 32'h0000_00AA);
      chk("fc_n0_idx", bus.out_idx, 10'd0);
      chk("fc_n0_clr", bus.acc_clr, 1'b1);
      tick();
      chk("fc_n0_valid_off", bus.out_valid, 1'b0);
      chk("fc_n0_clr_off", bus.acc_clr, 1'b0);
      chk("fc_addr1", bus.bias_addr, 10'd1);
      tick();
      chk("fc_n1_en0", bus.acc_enable, 1'b1);
      bus.acc_fc_done = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         tick();
         chk("fc_n1_en", bus.acc_enable, ((k < 15) && ((k % 5) < 3)) ? 1'b1 : 1'b0);
         chk("fc_early_done_ignored", bus.out_valid, 1'b0);
      end
      bus.acc_sum = 32'h0000_00BB;
      tick();
      bus.acc_fc_done = 1'b0;
      chk("fc_n1_valid", bus.out_valid, 1'b1);
      chk("fc_n1_data", bus.out_data, 32'h0000_00BB);
      chk("fc_n1_idx", bus.out_idx, 10'd1);
      chk("fc_n1_clr", bus.acc_clr, 1'b1);
      tick();
      chk("fc_done", bus.done, 1'b1);
      chk("fc_fin_clr", bus.acc_clr, 1'b1);
      chk("fc_no_back2back", bus.out_valid, 1'b0);
      tick();
      chk("fc_done_off", bus.done, 1'b0);
      chk("fc_idle_ready", bus.cmd_ready, 1'b1);

      // ---------------- FC stall: psum_valid low for 2 cycles mid-burst ----------------
      stall_pat = 12'b0011_1001_1111;
      issue(1'b1, 10'd1, 5'd1, 8'd3);
      chk("st_en_k0", bus.acc_enable, stall_pat[0]);
      for (int k = 1; k <= 11; k++) begin
         bus.psum_valid = !((k == 2) || (k == 3));
         tick();
         chk("st_en", bus.acc_enable, stall_pat[k]);
      end
      bus.psum_valid = 1'b1;
      tick();
      chk("st_wait_en", bus.acc_enable, 1'b0);
      bus.acc_fc_done = 1'b1;
      bus.acc_sum     = 32'h1234_5678;
      tick();
      bus.acc_fc_done = 1'b0;
      chk("st_valid", bus.out_valid, 1'b1);
      chk("st_data", bus.out_data, 32'h1234_5678);
      tick();
      chk("st_done", bus.done, 1'b1);
      tick();
      chk("st_idle", bus.busy, 1'b0);

      // ---------------- edge inputs: num_out = 0, beat_len = 0, fc_wcol = 0 ----------------
      issue(1'b1, 10'd0, 5'd0, 8'd0);
      chk("ed_en_k0", bus.acc_enable, 1'b1);
      bus.cmd_valid   = 1'b1;
      bus.cmd_layer   = 1'b0;
      bus.cmd_num_out = 10'd5;
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("ed_en", bus.acc_enable, 1'b0);
         chk("ed_ready_busy", bus.cmd_ready, 1'b0);
         chk("ed_busy", bus.busy, 1'b1);
      end
      bus.cmd_valid   = 1'b0;
      bus.acc_fc_done = 1'b1;
      bus.acc_sum     = 32'h0000_00CC;
      tick();
      bus.acc_fc_done = 1'b0;
      chk("ed_valid", bus.out_valid, 1'b1);
      chk("ed_idx", bus.out_idx, 10'd0);
      chk("ed_data", bus.out_data, 32'h0000_00CC);
      tick();
      chk("ed_done", bus.done, 1'b1);
      chk("ed_one_output", bus.out_valid, 1'b0);
      chk("ed_layer_kept", bus.acc_layer, 1'b1);
      tick();
      chk("ed_idle_ready", bus.cmd_ready, 1'b1);
      chk("ed_idle_valid", bus.out_valid, 1'b0);

`ifdef ACCUM_SCHED_TIMEOUT_EN
      // ---------------- watchdog: acc_fc_done never arrives ----------------
      issue(1'b1, 10'd1, 5'd0, 8'd1);
      tick(); tick(); tick();
      for (int j = 1; j <= 16; j++) begin
         tick();
         chk("wd_err", bus.err, (j == 16) ? 1'b1 : 1'b0);
         chk("wd_no_valid", bus.out_valid, 1'b0);
      end
      chk("wd_clr", bus.acc_clr, 1'b1);
      tick();
      chk("wd_done", bus.done, 1'b1);
      chk("wd_no_valid_fin", bus.out_valid, 1'b0);
      tick();
      chk("wd_idle", bus.busy, 1'b0);
      chk("wd_err_sticky", bus.err, 1'b1);
`else
      chk("err_tied", bus.err, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
